// File: rtl/pattern_data_sender_pkg.sv
// Shared definitions for the pattern data sender: word/counter widths,
// pattern seed width, the mixing constant of the pattern generator and the
// sender FSM state encoding.
package pattern_data_sender_pkg;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 32;
  localparam int PAT_W  = 32;

  // XOR'ed into the half-swapped index to form the low half of each word.
  localparam logic [31:0] GEN_MIX = 32'hA5A5_5A5A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pattern_data_sender_gen.sv
// data_generator: deterministic 64-bit pattern source shared with the
// write-path checker and host software.
// Word k after reset with seed p:  idx = p + k (mod 2^32)
//   word = { idx, {idx[15:0], idx[31:16]} ^ GEN_MIX }
// Ports:
//   clk     in   clock, posedge
//   rst     in   synchronous active-high reset, loads seed
//   enable  in   advance to the next word at the clock edge
//   seed    in   PAT_W pattern select/seed
//   word    out  DATA_W current word (combinational from the index)
module data_generator
  import pattern_data_sender_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [PAT_W-1:0]  seed,
  output logic [DATA_W-1:0] word
);

  logic [31:0] idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= seed;
    end else if (enable) begin
      idx <= idx + 32'd1;
    end
  end

  assign word = {idx, {idx[15:0], idx[31:16]} ^ GEN_MIX};

endmodule

// File: rtl/pattern_data_sender.sv
// pattern_data_sender: streams a known pattern into the host-bound FIFO.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for start; generator held in reset
//   ST_PRIME | one cycle: generator reset loads the latched pattern
//   ST_SEND  | write one word per cycle while FIFO not full and words remain
//   ST_DONE  | one cycle: done pulse, then back to idle
//
// Ports:
//   clk         in   clock, posedge
//   reset       in   synchronous active-low reset
//   start       in   begin transfer (only honoured in IDLE)
//   abort       in   cancel transfer, back to IDLE without done
//   word_count  in   CNT_W words to send, sampled on start
//   pattern     in   PAT_W generator seed, sampled on start
//   fifo_full   in   FIFO programmable-full (needs >=2 slots of slack)
//   fifo_din    out  DATA_W word to FIFO
//   fifo_wr_en  out  FIFO write strobe
//   busy        out  high in PRIME and SEND
//   done        out  one-cycle pulse after the last word
//   words_sent  out  CNT_W words written in the current/last transfer
module pattern_data_sender
  import pattern_data_sender_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [PAT_W-1:0]  pattern,
  input  logic              fifo_full,
  output logic [DATA_W-1:0] fifo_din,
  output logic              fifo_wr_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  words_sent
);

  state_t             state;
  logic [CNT_W-1:0]   remaining;
  logic [PAT_W-1:0]   pattern_q;
  logic               gen_reset;
  logic               enable_gener;
  logic [DATA_W-1:0]  gen_word;

  // Generator only runs in SEND; reloading in PRIME makes word 0 of every
  // transfer the first word after the latched seed.
  assign gen_reset = ~reset | (state == ST_IDLE) | (state == ST_PRIME);

  // Must match exactly the cycles in which a word is captured below, so the
  // generator advances once per written word.
  assign enable_gener = (state == ST_SEND) & ~fifo_full & (remaining != '0) & ~abort;

  data_generator u_gen (
    .clk    (clk),
    .rst    (gen_reset),
    .enable (enable_gener),
    .seed   (pattern_q),
    .word   (gen_word)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      pattern_q  <= '0;
      fifo_din   <= '0;
      fifo_wr_en <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      words_sent <= '0;
    end else if (abort) begin
      state      <= ST_IDLE;
      fifo_wr_en <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          fifo_wr_en <= 1'b0;
          done       <= 1'b0;
          if (start) begin
            remaining  <= word_count;
            pattern_q  <= pattern;
            words_sent <= '0;
            busy       <= 1'b1;
            state      <= ST_PRIME;
          end
        end
        ST_PRIME: begin
          state <= ST_SEND;
        end
        ST_SEND: begin
          if (remaining == '0) begin
            fifo_wr_en <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= ST_DONE;
          end else if (!fifo_full) begin
            fifo_din   <= gen_word;
            fifo_wr_en <= 1'b1;
            remaining  <= remaining - CNT_W'(1);
            words_sent <= words_sent + CNT_W'(1);
          end else begin
            fifo_wr_en <= 1'b0;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_data_sender.sv
module tb_pattern_data_sender;
  import pattern_data_sender_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [CNT_W-1:0]  word_count = '0;
  logic [PAT_W-1:0]  pattern = '0;
  logic              fifo_full = 1'b0;
  logic [DATA_W-1:0] fifo_din;
  logic              fifo_wr_en;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  words_sent;

  pattern_data_sender dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .word_count (word_count),
    .pattern    (pattern),
    .fifo_full  (fifo_full),
    .fifo_din   (fifo_din),
    .fifo_wr_en (fifo_wr_en),
    .busy       (busy),
    .done       (done),
    .words_sent (words_sent)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference pattern: k-th word after seeding with pat.
  function automatic logic [63:0] exp_word(input logic [31:0] pat, input int k);
    logic [31:0] idx;
    logic [31:0] lo;
    idx = pat + 32'(k);
    lo  = ((idx << 16) | (idx >> 16)) ^ 32'hA5A5_5A5A;
    return {idx, lo};
  endfunction

  // ---------------- model / compare process ----------------
  logic [31:0] cur_pat = '0;
  int xfer_id = 0;
  int seen_id = 0;
  int idx = 0;
  int done_cnt = 0;
  logic full_q = 1'b0;

  always @(posedge clk) full_q <= fifo_full;

  always @(negedge clk) begin
    if (xfer_id != seen_id) begin
      seen_id = xfer_id;
      idx = 0;
    end
    if (fifo_wr_en) begin
      check("stream_word", fifo_din, exp_word(cur_pat, idx));
      check("no_write_after_full", full_q, 1'b0);
      idx++;
    end
    if (done) done_cnt++;
  end

  // ---------------- fifo_full throttle (3 high / 2 low) ----------------
  int full_mode = 0;
  int phase = 0;
  always @(negedge clk) begin
    if (full_mode != 0) begin
      fifo_full = (phase < 3);
      phase = (phase + 1) % 5;
    end else begin
      fifo_full = 1'b0;
      phase = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [63:0] got_q[$];
  int          wcyc_q[$];

  task automatic start_xfer(input int cnt, input logic [31:0] pat);
    @(negedge clk);
    word_count = cnt;
    pattern    = pat;
    start      = 1'b1;
    cur_pat    = pat;
    xfer_id++;
    @(negedge clk);
    start      = 1'b0;
    word_count = $urandom;
    pattern    = $urandom;
  endtask

  // Called right after start_xfer; that negedge counts as cycle 1.
  task automatic run_to_done(input int limit, output int cyc);
    got_q.delete();
    wcyc_q.delete();
    cyc = 1;
    forever begin
      if (fifo_wr_en) begin
        got_q.push_back(fifo_din);
        wcyc_q.push_back(cyc);
      end
      if (done || cyc >= limit) break;
      @(negedge clk);
      cyc++;
    end
    check("done_seen", done, 1'b1);
  endtask

  task automatic wait_writes(input int n_req, output int n);
    int k;
    n = 0;
    k = 0;
    while (n < n_req && k < 300) begin
      @(negedge clk);
      k++;
      if (fifo_wr_en) n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    int n;
    logic [31:0] pa;
    logic [31:0] pb;

    // model pins
    check("model_pin_a", exp_word(32'h0001_0002, 1), 64'h00010003_A5A65A5B);
    check("model_pin_b", exp_word(32'hFFFF_FFFE, 2), 64'h00000000_A5A55A5A);

    // reset state
    repeat (3) @(negedge clk);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_din", fifo_din, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_words_sent", words_sent, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // T1: 4 words, no backpressure
    start_xfer(4, 32'h0);
    check("t1_busy_prime", busy, 1);
    run_to_done(50, cyc);
    check("t1_done_latency", cyc, 7);
    check("t1_nwrites", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check("t1_word0", got_q[0], 64'h00000000_A5A55A5A);
      check("t1_word3", got_q[3], 64'h00000003_A5A65A5A);
      check("t1_first_wr_cycle", wcyc_q[0], 3);
      check("t1_last_wr_cycle", wcyc_q[3], 6);
    end
    check("t1_words_sent", words_sent, 4);
    repeat (2) @(negedge clk);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_done_low", done, 0);
    check("t1_busy_low", busy, 0);

    // T2: 16 words with fifo_full toggling
    full_mode = 1;
    start_xfer(16, 32'h0);
    run_to_done(300, cyc);
    full_mode = 0;
    check("t2_nwrites", got_q.size(), 16);
    for (int i = 0; i < got_q.size(); i++) check("t2_word", got_q[i], exp_word(32'h0, i));
    if (wcyc_q.size() == 16) check("t2_stalled", (wcyc_q[15] - wcyc_q[0]) > 15, 1);
    check("t2_words_sent", words_sent, 16);
    repeat (2) @(negedge clk);
    check("t2_done_cnt", done_cnt, 2);

    // T3: zero-length transfer
    start_xfer(0, 32'h55);
    run_to_done(20, cyc);
    check("t3_done_latency", cyc, 3);
    check("t3_nwrites", got_q.size(), 0);
    check("t3_words_sent", words_sent, 0);
    repeat (2) @(negedge clk);
    check("t3_done_cnt", done_cnt, 3);

    // T4: abort after 10 writes, then restart
    start_xfer(100, 32'h1234_0000);
    wait_writes(10, n);
    check("t4_reached_10", n, 10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t4_abort_wr_en", fifo_wr_en, 0);
    check("t4_abort_busy", busy, 0);
    check("t4_abort_done", done, 0);
    check("t4_abort_words_sent", words_sent, 10);
    repeat (5) @(negedge clk);
    check("t4_no_done", done_cnt, 3);
    check("t4_model_idx", idx, 10);
    check("t4_words_sent_hold", words_sent, 10);
    start_xfer(3, 32'h1234_0000);
    run_to_done(30, cyc);
    check("t4r_nwrites", got_q.size(), 3);
    if (got_q.size() == 3) check("t4r_word0", got_q[0], 64'h12340000_A5A5486E);
    check("t4r_words_sent", words_sent, 3);
    repeat (2) @(negedge clk);
    check("t4r_done_cnt", done_cnt, 4);

    // T5: reset mid-SEND, then ignored starts in SEND and DONE
    start_xfer(20, 32'h7);
    wait_writes(5, n);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("t5_rst_wr_en", fifo_wr_en, 0);
    check("t5_rst_din", fifo_din, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_words_sent", words_sent, 0);
    repeat (3) @(negedge clk);
    start_xfer(5, 32'hCAFE_0001);
    wait_writes(1, n);
    word_count = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_to_done(60, cyc);
    check("t5_idx", idx, 5);
    check("t5_words_sent", words_sent, 5);
    word_count = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_ignored_busy", busy, 0);
    check("t5_ignored_words_sent", words_sent, 5);
    check("t5_done_cnt", done_cnt, 5);
    check("t5_idx_final", idx, 5);

    // T6: two transfers with different patterns
    pa = 32'hFFFF_FFFE;
    pb = 32'h0000_8000;
    start_xfer(3, pa);
    run_to_done(30, cyc);
    check("t6a_nwrites", got_q.size(), 3);
    for (int i = 0; i < got_q.size(); i++) check("t6a_word", got_q[i], exp_word(pa, i));
    if (got_q.size() == 3) check("t6a_word2_wrap", got_q[2], 64'h00000000_A5A55A5A);
    start_xfer(2, pb);
    run_to_done(30, cyc);
    check("t6b_nwrites", got_q.size(), 2);
    for (int i = 0; i < got_q.size(); i++) check("t6b_word", got_q[i], exp_word(pb, i));
    check("t6b_words_sent", words_sent, 2);
    repeat (2) @(negedge clk);
    check("t6_done_cnt", done_cnt, 7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
